// File: rtl/tare_avg_unit.sv
// rtl/tare_avg_unit.sv - averaging tare capture and net = gross - tare datapath
// Optional signed net output via TARE_SIGNED_NET_EN.
module tare_avg_unit #(
    parameter int             W         = 12,
    parameter int             AVG_LOG2  = 2,
    parameter logic [W-1:0]   TARE_INIT = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] sample_in,
    input  logic         sample_valid,
    input  logic         tare_req,
    input  logic         tare_clear,
    output logic [W-1:0] net_out,
    output logic         net_neg,
    output logic         net_valid,
    output logic [W-1:0] tare_out,
    output logic         tare_busy
);

    localparam int ACC_W = W + AVG_LOG2;
    localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {
        TRACK,
        AVG
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   cnt;
    logic               last_sample;
    logic [W:0]         diff;
    logic [W-1:0]       mag;
    logic               below_tare;
    logic [W-1:0]       net_d;
    logic               neg_d;

    assign acc_sum     = acc + ACC_W'(sample_in);
    assign last_sample = (state_q == AVG) && sample_valid && (cnt == CNT_LAST);
    assign tare_busy   = (state_q == AVG);

    // W+1 bit subtraction: the top bit is the borrow, i.e. sample < tare.
    assign diff       = {1'b0, sample_in} - {1'b0, tare_out};
    assign below_tare = diff[W];
    assign mag        = tare_out - sample_in;

    always_comb begin
        net_d = diff[W-1:0];
        neg_d = 1'b0;
`ifdef TARE_SIGNED_NET_EN
        if (below_tare) begin
            net_d = mag;
            neg_d = 1'b1;
        end
`else
        if (below_tare) begin
            net_d = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        if (tare_clear) begin
            state_d = TRACK;
        end else begin
            case (state_q)
                TRACK:   if (tare_req) state_d = AVG;
                AVG:     if (last_sample) state_d = TRACK;
                default: state_d = TRACK;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= TRACK;
            acc       <= '0;
            cnt       <= '0;
            tare_out  <= TARE_INIT;
            net_out   <= '0;
            net_neg   <= 1'b0;
            net_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            net_valid <= sample_valid;
            if (sample_valid) begin
                net_out <= net_d;
                net_neg <= neg_d;
            end
            if (tare_clear) begin
                tare_out <= '0;
                acc      <= '0;
                cnt      <= '0;
            end else if (state_q == AVG) begin
                if (last_sample) begin
                    tare_out <= W'(acc_sum >> AVG_LOG2);
                    acc      <= '0;
                    cnt      <= '0;
                end else if (sample_valid) begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end else if (tare_req) begin
                acc <= '0;
                cnt <= '0;
            end
        end
    end

`ifndef TARE_SIGNED_NET_EN
    logic unused_mag;
    assign unused_mag = ^mag;
`endif

endmodule
